rc_pulse_gen: RTL

- Generates an RC servo/ESC PWM signal from a signed 10-bit command.
- It is the transmit-side counterpart of the RC pulse measurer. It uses the same command format: two's complement −512..+511, with 0 = neutral, 1 µs per LSB around a 1500 µs centre.
- Sits between the motor/steering control logic and the servo output pins.
- Provides a fixed frame rate, glitch-free width updates at frame boundaries, and a failsafe to neutral if commands stop arriving.

---
 rtl/rc_pulse_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rc_pulse_gen.sv
// RC servo/ESC PWM generator: signed 10-bit command -> 1 us/LSB pulse around CENTER_US,
// fixed frame period, width updates only at frame boundaries, neutral failsafe on silence.
module rc_pulse_gen #(
    parameter int unsigned PREDIV          = 50,
    parameter int unsigned FRAME_US        = 20000,
    parameter int unsigned CENTER_US       = 1500,
    parameter int unsigned MIN_US          = 1000,
    parameter int unsigned MAX_US          = 2000,
    parameter int unsigned FAILSAFE_FRAMES = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ack,
    output logic       pulse_out,
    output logic       frame_start,
    output logic       failsafe
);

    localparam int unsigned PreW  = (PREDIV > 1) ? $clog2(PREDIV) : 1;
    localparam int unsigned UsW   = $clog2(FRAME_US);
    localparam int unsigned MissW = $clog2(FAILSAFE_FRAMES + 1);
    localparam int unsigned SumW  = (UsW + 2 > 12) ? UsW + 2 : 12;

    localparam logic [PreW-1:0]         PreLast  = PreW'(PREDIV - 1);
    localparam logic [UsW-1:0]          UsLast   = UsW'(FRAME_US - 1);
    localparam logic [UsW-1:0]          CenterW  = UsW'(CENTER_US);
    localparam logic [UsW-1:0]          MinW     = UsW'(MIN_US);
    localparam logic [UsW-1:0]          MaxW     = UsW'(MAX_US);
    localparam logic [MissW-1:0]        MissMax  = MissW'(FAILSAFE_FRAMES);
    localparam logic signed [SumW-1:0]  CenterS  = SumW'(CENTER_US);
    localparam logic signed [SumW-1:0]  MinS     = SumW'(MIN_US);
    localparam logic signed [SumW-1:0]  MaxS     = SumW'(MAX_US);

    if (MAX_US >= FRAME_US) begin : g_bad_max
        $error("rc_pulse_gen: MAX_US must be below FRAME_US");
    end
    if (MIN_US < 1 || MIN_US > MAX_US) begin : g_bad_min
        $error("rc_pulse_gen: need 1 <= MIN_US <= MAX_US");
    end

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e           state_q, state_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [UsW-1:0]   us_q, us_d;
    logic [UsW-1:0]   pending_q, pending_d;
    logic [UsW-1:0]   active_q, active_d;
    logic [MissW-1:0] miss_q, miss_d;
    logic             failsafe_q, failsafe_d;
    logic             ack_q, ack_d;
    logic             fstart_q, fstart_d;
    logic             pulse_q, pulse_d;

    logic                  tick, boundary;
    logic signed [SumW-1:0] sum_w;
    logic [UsW-1:0]        clamp_w;

    always_comb begin
        tick     = (pre_q == PreLast);
        boundary = tick && (us_q == UsLast);
        pre_d    = tick ? '0 : pre_q + 1'b1;
        us_d     = us_q;
        if (tick) begin
            us_d = (us_q == UsLast) ? '0 : us_q + 1'b1;
        end
    end

    // Sign-extended sum is wide enough that no command can wrap past the clamps.
    always_comb begin
        sum_w   = CenterS + $signed({{(SumW - 10){cmd[9]}}, cmd});
        clamp_w = sum_w[UsW-1:0];
        if (sum_w < MinS) begin
            clamp_w = MinW;
        end else if (sum_w > MaxS) begin
            clamp_w = MaxW;
        end
    end

    always_comb begin
        pending_d  = pending_q;
        active_d   = active_q;
        miss_d     = miss_q;
        failsafe_d = failsafe_q;
        ack_d      = cmd_valid;
        fstart_d   = boundary;
        if (boundary) begin
            active_d = failsafe_q ? CenterW : pending_q;
        end
        if (cmd_valid) begin
            pending_d  = clamp_w;
            miss_d     = '0;
            failsafe_d = 1'b0;
        end else if (boundary) begin
            if (miss_q != MissMax) begin
                miss_d = miss_q + 1'b1;
            end
            if (miss_d == MissMax) begin
                failsafe_d = 1'b1;
            end
        end
    end

    // HIGH ignores enable so a dropped enable never truncates a pulse in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (boundary && enable) state_d = StHigh;
            StHigh: if (tick && us_q == active_q - 1'b1) state_d = StLow;
            StLow:  if (boundary) state_d = enable ? StHigh : StIdle;
            default: state_d = StIdle;
        endcase
        pulse_d = (state_d == StHigh);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pre_q      <= '0;
            us_q       <= '0;
            pending_q  <= CenterW;
            active_q   <= CenterW;
            miss_q     <= '0;
            failsafe_q <= 1'b1;
            ack_q      <= 1'b0;
            fstart_q   <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            us_q       <= us_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            miss_q     <= miss_d;
            failsafe_q <= failsafe_d;
            ack_q      <= ack_d;
            fstart_q   <= fstart_d;
            pulse_q    <= pulse_d;
        end
    end

    assign cmd_ack     = ack_q;
    assign pulse_out   = pulse_q;
    assign frame_start = fstart_q;
    assign failsafe    = failsafe_q;

endmodule
